pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Hazard and sequencing controller for the 5-stage Y86-64 pipeline.
//  - Drives the stall/bubble inputs of the F, D, E, M and W pipe_reg stages.
//  - Detects load-use, ret and branch-mispredict hazards.
//  - Gates condition-code updates.
//  - Runs a start-up/halt state machine, with optional performance counters.
// PARAMETERS
//  CNT_W    32  width of each performance counter (used only with PIPE_PERF_EN)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active high
//  D_icode    in   4      icode in the D register
//  d_srcA     in   4      decode-stage srcA (4'hF = none)
//  d_srcB     in   4      decode-stage srcB (4'hF = none)
//  E_icode    in   4      icode in the E register
//  E_dstM     in   4      dstM in the E register (4'hF = none)
//  e_Cnd      in   1      execute-stage branch condition
//  M_icode    in   4      icode in the M register
//  m_stat     in   2      memory-stage status
//  W_icode    in   4      icode in the W register
//  W_stat     in   2      write-back status
//  F_stall    out  1      hold PC / F register
//  D_stall    out  1      hold D register
//  D_bubble   out  1      load NOP into D
//  E_bubble   out  1      load NOP into E
//  M_bubble   out  1      load NOP into M
//  W_stall    out  1      hold W register
//  set_cc     out  1      allow the ALU to update CC this cycle
//  halted     out  1      pipeline frozen on a non-AOK status
//  cyc_cnt    out  CNT_W  cycles spent in RUN
//  ret_cnt    out  CNT_W  instructions retired
//  stl_cnt    out  CNT_W  cycles with F_stall=1 in RUN
// BEHAVIOUR
//  FSM states (registered): INIT -> RUN -> HALT.
//   - rst=1 forces INIT.
//   - INIT lasts exactly 1 cycle after rst falls, then moves to RUN.
//   - RUN -> HALT on the first clock edge where W_stat != STAT_AOK.
//   - HALT is sticky until rst. rst has priority in every state, including mid-HALT.
//  Control outputs are combinational from the state and the inputs.
//  INIT (also while rst=1):
//   - F_stall=1, D_bubble=E_bubble=M_bubble=1.
//   - D_stall=W_stall=0, set_cc=0, halted=0.
//  RUN hazard terms:
//   - lu = (E_icode==MRMOVQ || E_icode==POPQ) && E_dstM!=RNONE && (E_dstM==d_srcA || E_dstM==d_srcB).
//   - rt = RET in any of D_icode, E_icode, M_icode.
//   - mp = E_icode==JXX && !e_Cnd.
//   - exc = m_stat!=AOK || W_stat!=AOK.
//  RUN outputs:
//   - F_stall = lu | rt.
//   - D_stall = lu.
//   - D_bubble = mp | (rt & ~lu).
//   - E_bubble = mp | lu.
//   - M_bubble = exc.
//   - W_stall = (W_stat!=AOK).
//   - set_cc = E_icode==OPQ & ~exc.
//  Simultaneous hazards:
//   - mp+rt (JXX in E, RET in D): D_bubble=1, E_bubble=1, F_stall=1.
//   - lu+rt: D is stalled, not bubbled.
//   - D_stall and D_bubble are never both 1.
//  HALT outputs:
//   - F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1.
//   - D_bubble=0, set_cc=0, halted=1.
//  Latency: zero-cycle combinational path from the hazard inputs to the controls; one-cycle latency for state changes.
// CONFIGURATION
//  PIPE_PERF_EN defined:
//   - Three CNT_W counters; all clear on rst.
//   - cyc_cnt increments on every RUN cycle.
//   - ret_cnt increments on a RUN cycle with W_icode!=NOP && W_stat==AOK.
//   - stl_cnt increments on a RUN cycle with F_stall=1.
//   - Every counter saturates at all-ones (no wrap).
//   - Counters freeze in INIT and HALT.
//  PIPE_PERF_EN undefined: no counter flops; cyc_cnt/ret_cnt/stl_cnt are tied to 0.
// STRUCTURE
//  Shared package/include y86_defs.vh holds:
//   - icode constants: HALT=0, NOP=1, RRMOVQ=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B.
//   - RNONE=4'hF.
//   - Status codes: STAT_AOK=0, STAT_HLT=1, STAT_ADR=2, STAT_INS=3.
//   - FSM state encodings: INIT=0, RUN=1, HALT=2.
//  One combinational sub-module, hazard_detect, produces lu/rt/mp/exc. The FSM and counters live in pipe_ctrl.
// TESTING
//  1. rst=1 for 2 cycles, then 0:
//     - 1 cycle INIT with F_stall=1 and D/E/M_bubble=1.
//     - Next cycle RUN with all controls 0 for NOP inputs.
//  2. Load-use: E_icode=5, E_dstM=3, d_srcA=3:
//     - F_stall=1, D_stall=1, E_bubble=1, D_bubble=0.
//     - Same with d_srcA=d_srcB=E_dstM=4'hF: no stall.
//  3. Ret: D_icode=9 held 3 cycles as it walks to E, then M:
//     - F_stall=1 and D_bubble=1 on each of the 3 cycles.
//     - Clear on the 4th cycle.
//  4. Mispredict: E_icode=7, e_Cnd=0, D_icode=9: D_bubble=1, E_bubble=1, F_stall=1. With e_Cnd=1 only the ret terms remain.
//  5. Exception / halt:
//     - E_icode=6 with m_stat=2: set_cc=0, M_bubble=1.
//     - W_stat=1: W_stall=1 that cycle, halted=1 from the next edge, and it persists with W_stat back at 0.
//     - rst mid-HALT returns to INIT.
//  6. PIPE_PERF_EN build:
//     - 10 RUN cycles with 4 retiring non-NOP W_icode and 2 stall cycles give cyc=10, ret=4, stl=2.
//     - CNT_W=4: cyc_cnt saturates at 15.
//     - Default build: all counters read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared Y86-64 definitions used by the pipeline controller:
//     - instruction codes (icode field)
//     - register specifier "no register"
//     - status codes carried alongside each pipe stage
//     - controller FSM state encodings
//     - hazard_t: the bundle of hazard terms produced by hazard_detect
//   No ports (package).
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Register specifier meaning "no register"
  localparam logic [3:0] RNONE = 4'hF;

  // Status codes
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  // Controller FSM state encodings
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // Hazard terms seen in the current cycle
  typedef struct packed {
    logic lu;   // load/use: value loaded in E is needed by decode
    logic rt;   // ret somewhere in D, E or M
    logic mp;   // conditional jump in E was mispredicted (predicted taken)
    logic exc;  // non-AOK status in M or W
  } hazard_t;

  // Instructions whose result arrives from memory (writes dstM late)
  function automatic logic is_mem_load(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_hazard (module hazard_detect)
//   Purely combinational hazard classification for the 5-stage pipeline.
//   Ports:
//     i_d_icode  in  4  icode in the D register
//     i_d_srca   in  4  decode-stage srcA (RNONE = none)
//     i_d_srcb   in  4  decode-stage srcB (RNONE = none)
//     i_e_icode  in  4  icode in the E register
//     i_e_dstm   in  4  dstM in the E register (RNONE = none)
//     i_e_cnd    in  1  execute-stage branch condition
//     i_m_icode  in  4  icode in the M register
//     i_m_stat   in  2  memory-stage status
//     i_w_stat   in  2  write-back status
//     o_lu       out 1  load/use hazard
//     o_rt       out 1  ret in flight (D, E or M)
//     o_mp       out 1  branch mispredict
//     o_exc      out 1  exception status in M or W
// -----------------------------------------------------------------------------
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] i_d_icode,
  input  logic [3:0] i_d_srca,
  input  logic [3:0] i_d_srcb,
  input  logic [3:0] i_e_icode,
  input  logic [3:0] i_e_dstm,
  input  logic       i_e_cnd,
  input  logic [3:0] i_m_icode,
  input  logic [1:0] i_m_stat,
  input  logic [1:0] i_w_stat,
  output logic       o_lu,
  output logic       o_rt,
  output logic       o_mp,
  output logic       o_exc
);

  hazard_t w_hz;

  always_comb begin
    w_hz = '0;
    // RNONE is excluded explicitly: decode reports unused sources as RNONE,
    // so a load with no dstM must not match them.
    w_hz.lu  = is_mem_load(i_e_icode) && (i_e_dstm != RNONE) &&
               ((i_e_dstm == i_d_srca) || (i_e_dstm == i_d_srcb));
    w_hz.rt  = (i_d_icode == I_RET) || (i_e_icode == I_RET) ||
               (i_m_icode == I_RET);
    // Jumps are predicted taken, so a not-taken condition is the mispredict.
    w_hz.mp  = (i_e_icode == I_JXX) && !i_e_cnd;
    w_hz.exc = (i_m_stat != STAT_AOK) || (i_w_stat != STAT_AOK);
  end

  assign o_lu  = w_hz.lu;
  assign o_rt  = w_hz.rt;
  assign o_mp  = w_hz.mp;
  assign o_exc = w_hz.exc;

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//   Hazard and sequencing controller for the 5-stage Y86-64 pipeline.
//   Drives stall/bubble controls of the F, D, E, M and W pipe registers,
//   gates condition-code updates and runs an INIT -> RUN -> HALT sequencer.
//
//   Build option: PIPE_PERF_EN
//     defined   : three saturating CNT_W-bit performance counters
//     undefined : no counter flops, counter outputs tied to 0
//
//   Parameters:
//     CNT_W      width of each performance counter
//   Ports:
//     clk        in   1      rising-edge clock
//     rst        in   1      synchronous reset, active high
//     D_icode    in   4      icode in D
//     d_srcA     in   4      decode srcA (4'hF = none)
//     d_srcB     in   4      decode srcB (4'hF = none)
//     E_icode    in   4      icode in E
//     E_dstM     in   4      dstM in E (4'hF = none)
//     e_Cnd      in   1      execute branch condition
//     M_icode    in   4      icode in M
//     m_stat     in   2      memory-stage status
//     W_icode    in   4      icode in W
//     W_stat     in   2      write-back status
//     F_stall    out  1      hold PC / F register
//     D_stall    out  1      hold D register
//     D_bubble   out  1      load NOP into D
//     E_bubble   out  1      load NOP into E
//     M_bubble   out  1      load NOP into M
//     W_stall    out  1      hold W register
//     set_cc     out  1      allow ALU CC update this cycle
//     halted     out  1      pipeline frozen on non-AOK status
//     cyc_cnt    out  CNT_W  cycles spent in RUN
//     ret_cnt    out  CNT_W  instructions retired
//     stl_cnt    out  CNT_W  RUN cycles with F_stall=1
//     dbg_state  out  2      current FSM state (debug visibility)
//
//   All stall/bubble outputs are combinational from state and inputs; state
//   changes take effect one clock later.
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [1:0]       m_stat,
  input  logic [3:0]       W_icode,
  input  logic [1:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] stl_cnt,
  output logic [1:0]       dbg_state
);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       w_lu;
  logic       w_rt;
  logic       w_mp;
  logic       w_exc;
  logic       w_run;

  hazard_detect u_hazard (
    .i_d_icode (D_icode),
    .i_d_srca  (d_srcA),
    .i_d_srcb  (d_srcB),
    .i_e_icode (E_icode),
    .i_e_dstm  (E_dstM),
    .i_e_cnd   (e_Cnd),
    .i_m_icode (M_icode),
    .i_m_stat  (m_stat),
    .i_w_stat  (W_stat),
    .o_lu      (w_lu),
    .o_rt      (w_rt),
    .o_mp      (w_mp),
    .o_exc     (w_exc)
  );

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: w_state_nxt = ST_RUN;
      ST_RUN:  if (W_stat != STAT_AOK) w_state_nxt = ST_HALT;
      ST_HALT: w_state_nxt = ST_HALT;  // only rst leaves HALT
      default: w_state_nxt = ST_INIT;  // unused encoding recovers via INIT
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_INIT;
    else     r_state <= w_state_nxt;
  end

  assign dbg_state = r_state;
  // rst is folded in so the controls already show the INIT pattern while
  // reset is asserted, before the state register has been reloaded.
  assign w_run = !rst && (r_state == ST_RUN);

  // ---------------------------------------------------------------------------
  // Pipeline controls
  // ---------------------------------------------------------------------------
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    set_cc   = 1'b0;
    halted   = 1'b0;
    if (w_run) begin
      F_stall  = w_lu | w_rt;
      D_stall  = w_lu;
      // A load/use stall on D takes priority over the ret bubble so the
      // instruction waiting in D is held instead of being squashed.
      D_bubble = w_mp | (w_rt & ~w_lu);
      E_bubble = w_mp | w_lu;
      M_bubble = w_exc;
      W_stall  = (W_stat != STAT_AOK);
      set_cc   = (E_icode == I_OPQ) & ~w_exc;
    end else if (!rst && (r_state == ST_HALT)) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
      halted   = 1'b1;
    end else begin
      // INIT, reset, or an unused state encoding: flush everything upstream.
      F_stall  = 1'b1;
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] r_ret_cnt;
  logic [CNT_W-1:0] r_stl_cnt;
  logic             w_retire;

  assign w_retire = (W_icode != I_NOP) && (W_stat == STAT_AOK);

  // Each counter stops at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc_cnt <= '0;
      r_ret_cnt <= '0;
      r_stl_cnt <= '0;
    end else if (w_run) begin
      if (r_cyc_cnt != '1)
        r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
      if (w_retire && (r_ret_cnt != '1))
        r_ret_cnt <= r_ret_cnt + CNT_W'(1);
      if (F_stall && (r_stl_cnt != '1))
        r_stl_cnt <= r_stl_cnt + CNT_W'(1);
    end
  end

  assign cyc_cnt = r_cyc_cnt;
  assign ret_cnt = r_ret_cnt;
  assign stl_cnt = r_stl_cnt;
`else
  // W_icode only feeds the retire counter; reduce it into a sink here.
  logic w_unused_w_icode;
  assign w_unused_w_icode = ^W_icode;

  assign cyc_cnt = '0;
  assign ret_cnt = '0;
  assign stl_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  // Output bit order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble,
  //                    W_stall, set_cc, halted}
  localparam logic [7:0] P_INIT = 8'b1011_1000;
  localparam logic [7:0] P_HALT = 8'b1101_1101;
  localparam logic [7:0] P_IDLE = 8'b0000_0000;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
  logic       e_Cnd;
  logic [1:0] m_stat, W_stat;
  logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
  logic       set_cc, halted;
  logic [31:0] cyc_cnt, ret_cnt, stl_cnt;
  logic [1:0]  dbg_state;
  logic [7:0]  outs;

  always #5 clk = ~clk;

  assign outs = {F_stall, D_stall, D_bubble, E_bubble, M_bubble,
                 W_stall, set_cc, halted};

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat),
    .W_icode(W_icode), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .set_cc(set_cc), .halted(halted),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stl_cnt(stl_cnt),
    .dbg_state(dbg_state)
  );

`ifdef PIPE_PERF_EN
  logic [3:0] cyc4, ret4, stl4;
  logic       n_f, n_ds, n_db, n_eb, n_mb, n_ws, n_cc, n_h;
  logic [1:0] n_st;
  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat),
    .W_icode(W_icode), .W_stat(W_stat),
    .F_stall(n_f), .D_stall(n_ds), .D_bubble(n_db),
    .E_bubble(n_eb), .M_bubble(n_mb), .W_stall(n_ws),
    .set_cc(n_cc), .halted(n_h),
    .cyc_cnt(cyc4), .ret_cnt(ret4), .stl_cnt(stl4),
    .dbg_state(n_st)
  );
`endif

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_outs(input string name, input logic [7:0] exp);
    exp_q.push_back({24'd0, exp});
    check(name, {24'd0, outs});
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change on the falling edge, sampled 2 ns later)
  // ---------------------------------------------------------------------------
  task automatic drive_nop();
    D_icode = I_NOP; d_srcA = RNONE; d_srcB = RNONE;
    E_icode = I_NOP; E_dstM = RNONE; e_Cnd = 1'b0;
    M_icode = I_NOP; m_stat = STAT_AOK;
    W_icode = I_NOP; W_stat = STAT_AOK;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  // Reset for two edges, then leave the bench at the start of the INIT cycle.
  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    drive_nop();
    repeat (2) @(posedge clk);
    next_cycle();
    rst = 1'b0;
    settle();
  endtask

  // ---------------------------------------------------------------------------
  // Vector table (RUN state, W stage idle and AOK)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] d_icode;
    logic [3:0] srca;
    logic [3:0] srcb;
    logic [3:0] e_icode;
    logic [3:0] e_dstm;
    logic       e_cnd;
    logic [3:0] m_icode;
    logic [1:0] m_stat;
    logic [7:0] exp;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic [3:0] di, input logic [3:0] sa,
                              input logic [3:0] sb, input logic [3:0] ei,
                              input logic [3:0] ed, input logic ec,
                              input logic [3:0] mi, input logic [1:0] ms,
                              input logic [7:0] ex);
    vec_t v;
    v.d_icode = di; v.srca = sa; v.srcb = sb; v.e_icode = ei; v.e_dstm = ed;
    v.e_cnd = ec; v.m_icode = mi; v.m_stat = ms; v.exp = ex;
    return v;
  endfunction

  initial begin
    //            D     srcA   srcB   E      dstM   cnd M     mstat  F D Db Eb Mb Ws cc h
    vecs[0]  = mk(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 0, 4'h1, 2'd0, 8'b0000_0000); // all NOP
    vecs[1]  = mk(4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 0, 4'h1, 2'd0, 8'b1101_0000); // mrmovq load/use srcA
    vecs[2]  = mk(4'h1, 4'hF, 4'h2, 4'hB, 4'h2, 0, 4'h1, 2'd0, 8'b1101_0000); // popq load/use srcB
    vecs[3]  = mk(4'h1, 4'hF, 4'hF, 4'h5, 4'hF, 0, 4'h1, 2'd0, 8'b0000_0000); // RNONE never matches
    vecs[4]  = mk(4'h1, 4'h4, 4'h5, 4'h5, 4'h3, 0, 4'h1, 2'd0, 8'b0000_0000); // load, no dependency
    vecs[5]  = mk(4'h1, 4'h3, 4'hF, 4'h3, 4'h3, 0, 4'h1, 2'd0, 8'b0000_0000); // irmovq is not a load
    vecs[6]  = mk(4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 0, 4'h1, 2'd0, 8'b1010_0000); // ret in D
    vecs[7]  = mk(4'h9, 4'hF, 4'hF, 4'h7, 4'hF, 0, 4'h1, 2'd0, 8'b1011_0000); // mispredict + ret
    vecs[8]  = mk(4'h9, 4'hF, 4'hF, 4'h7, 4'hF, 1, 4'h1, 2'd0, 8'b1010_0000); // taken jump + ret
    vecs[9]  = mk(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 0, 4'h1, 2'd0, 8'b0011_0000); // mispredict only
    vecs[10] = mk(4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 0, 4'h9, 2'd0, 8'b1101_0000); // load/use + ret in M
    vecs[11] = mk(4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 0, 4'h1, 2'd0, 8'b0000_0010); // opq sets CC
    vecs[12] = mk(4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 0, 4'h1, 2'd2, 8'b0000_1000); // opq, m_stat=ADR
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    drive_nop();

    // 1. Reset and start-up
    settle();
    expect_outs("reset_outs", P_INIT);
    do_reset();
    expect_outs("init_outs", P_INIT);
    exp_q.push_back({30'd0, ST_INIT});
    check("init_state", {30'd0, dbg_state});
    next_cycle(); settle();
    expect_outs("run_idle_outs", P_IDLE);
    exp_q.push_back({30'd0, ST_RUN});
    check("run_state", {30'd0, dbg_state});

    // 2. Table of single-cycle hazard combinations
    for (int i = 0; i < NVEC; i++) begin
      next_cycle();
      drive_nop();
      D_icode = vecs[i].d_icode; d_srcA = vecs[i].srca; d_srcB = vecs[i].srcb;
      E_icode = vecs[i].e_icode; E_dstM = vecs[i].e_dstm;
      e_Cnd = vecs[i].e_cnd; M_icode = vecs[i].m_icode;
      m_stat = vecs[i].m_stat;
      settle();
      expect_outs($sformatf("vec%0d", i), vecs[i].exp);
    end

    // 3. ret walking D -> E -> M, then gone
    next_cycle(); drive_nop(); D_icode = I_RET; settle();
    expect_outs("ret_in_d", 8'b1010_0000);
    next_cycle(); drive_nop(); E_icode = I_RET; settle();
    expect_outs("ret_in_e", 8'b1010_0000);
    next_cycle(); drive_nop(); M_icode = I_RET; settle();
    expect_outs("ret_in_m", 8'b1010_0000);
    next_cycle(); drive_nop(); settle();
    expect_outs("ret_clear", P_IDLE);

    // 4. Halt on W_stat, stickiness, reset out of HALT
    next_cycle(); W_stat = STAT_HLT; settle();
    expect_outs("halt_entry", 8'b0000_1100);
    next_cycle(); W_stat = STAT_AOK; settle();
    expect_outs("halted", P_HALT);
    next_cycle(); E_icode = I_MRMOVQ; E_dstM = 4'h3; d_srcA = 4'h3; settle();
    expect_outs("halt_sticky", P_HALT);
    next_cycle(); drive_nop(); rst = 1'b1; settle();
    expect_outs("rst_in_halt", P_INIT);
    next_cycle(); rst = 1'b0; settle();
    expect_outs("post_halt_init", P_INIT);
    exp_q.push_back({30'd0, ST_INIT});
    check("post_halt_state", {30'd0, dbg_state});
    next_cycle(); settle();
    expect_outs("post_halt_run", P_IDLE);

`ifdef PIPE_PERF_EN
    // 6. Counters: 10 RUN cycles, 4 retirements, 2 stalls
    do_reset();                 // INIT cycle
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive_nop();
      if (i < 4) W_icode = I_OPQ;
      if (i == 5 || i == 6) D_icode = I_RET;
    end
    next_cycle(); drive_nop(); settle();
    exp_q.push_back(32'd10); check("cyc_cnt", cyc_cnt);
    exp_q.push_back(32'd4);  check("ret_cnt", ret_cnt);
    exp_q.push_back(32'd2);  check("stl_cnt", stl_cnt);
    // Counters hold in HALT
    W_stat = STAT_HLT;            // this RUN cycle still counts
    next_cycle(); W_stat = STAT_AOK;
    repeat (3) next_cycle();
    settle();
    exp_q.push_back(32'd11); check("cyc_frozen_halt", cyc_cnt);
    // 4-bit saturation
    do_reset();
    repeat (20) next_cycle();
    settle();
    exp_q.push_back(32'd15); check("cyc4_saturate", {28'd0, cyc4});
`else
    // Default build: counters tied off after many RUN cycles
    exp_q.push_back(32'd0); check("cyc_cnt_off", cyc_cnt);
    exp_q.push_back(32'd0); check("ret_cnt_off", ret_cnt);
    exp_q.push_back(32'd0); check("stl_cnt_off", stl_cnt);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
